crc_mem_stream_reader: RTL and testbench
========================================

# crc_mem_stream_reader

Avalon-style read master that streams a contiguous block of 32-bit words from the CRC SoC on-chip memory (64K × 32, single-port, 1-cycle read latency) into the CRC engine's input stream. Software or a controller supplies a base word address and a length. The block issues one read per cycle while buffer credit allows and presents the returned words on a valid/ready stream, marking the final word. It sits directly downstream of the on-chip memory and directly upstream of the CRC datapath.

## Interface
Parameters:
- `MEM_AW`, 16: memory word-address width.
- `DW`, 32: data width.
- `FIFO_DEPTH`, 4: output buffer depth in words; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  MEM_AW  first word address; captured on accepted `start`.
- `len_words`  in  MEM_AW+1  word count, 0..65536; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `mem_address`  out  MEM_AW  read address to the memory.
- `mem_chipselect`  out  1  read strobe; the memory returns data one cycle later.
- `mem_write`  out  1  tied 0.
- `mem_byteenable`  out  4  tied 4'hF.
- `mem_clken`  out  1  tied 1.
- `mem_readdata`  in  DW  memory read data.
- `out_data`  out  DW  stream word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word; transfer occurs when valid and ready are both high.
- `out_last`  out  1  qualifies the final word of the block.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on `start`, latch `base_addr` and `len_words` and clear all counters.
    - If `len_words`==0, go to DONE. No reads are issued and no stream words are produced.
    - Otherwise go to RUN.
  - RUN: assert `mem_chipselect` with `mem_address` = base + issued_count (mod 2^MEM_AW) when (fifo_count + inflight) < FIFO_DEPTH. Both terms are registered values, so there is no combinational path from `out_ready` to `mem_chipselect`. When issued_count reaches len, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, inflight is 0, and the last word has transferred; then go to DONE.
  - DONE: `done`=1 for one cycle, then return to IDLE.
- inflight is a 1-bit register: it is set in any cycle with `mem_chipselect`=1. In the following cycle `mem_readdata` is pushed into the FIFO.
- `out_last` = 1 when the FIFO head is word index len-1. Track this with a popped-word counter compared against len-1.
- Address wraps modulo 2^MEM_AW. For example, base 16'hFFFE with len 4 reads FFFE, FFFF, 0000, 0001.
- `start` while busy is ignored; the latched parameters do not change.
- FIFO overflow is impossible by the credit rule. A push into a full FIFO is an assertion failure.
- Reset mid-transfer: all state is cleared immediately, the FIFO is flushed, and any read in flight is discarded.
- Reset values: `busy`=0, `done`=0, `mem_chipselect`=0, `mem_address`=0, `out_valid`=0, `out_last`=0, `out_data`=0, FSM=IDLE.

## Timing
- Cycle 0: `start` is sampled at a rising edge.
- Cycle 1: RUN begins and the first `mem_chipselect` is issued.
- Cycle 2: `mem_readdata` is valid and is pushed into the FIFO at the end of the cycle.
- Cycle 3: `out_valid`=1.
- Start-to-first-valid latency is therefore 3 cycles.
- With `out_ready` held high, throughput is sustained at 1 word/cycle.
- With len=N and `out_ready` high, `done` asserts in cycle N+3 (the cycle after the last transfer in cycle N+2). `busy` falls with `done`.
- `out_data`, `out_valid`, and `out_last` are held stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Package `crc_soc_pkg` holds:
  - the FSM state enum `rd_state_t`;
  - constants `MEM_AW`=16, `DW`=32, and `MEM_WORDS`=65536.
- Sub-module `crc_sync_fifo`: a single-clock FIFO, DW × FIFO_DEPTH, with a registered count, first-word-fall-through output, and simultaneous push/pop allowed when full or empty.
- The FSM, address and issue counters, inflight flag, and last-word tracking live in the top module.

## Test plan
- Memory preloaded with word = address; base 0x0010, len 8, `out_ready`=1. Required response:
  - words 0x10..0x17 appear on consecutive cycles starting at cycle 3;
  - `out_last` is high only on 0x17;
  - `done` is high in cycle 11.
- len 0: `done` pulses in cycle 1; `mem_chipselect` and `out_valid` never assert.
- Wrap case: base 0xFFFE, len 4. The stream is 0xFFFE, 0xFFFF, 0x0000, 0x0001, with `out_last` on 0x0001.
- Backpressure: len 16 with `out_ready` random at 30%. Required response:
  - all 16 words arrive in order with no loss or duplication;
  - (fifo_count + inflight) never exceeds 4;
  - output signals stay stable while stalled.
- A second `start` with different parameters mid-transfer is ignored, and the original 8-word block completes unchanged.
- Assert `reset` asynchronously during word 5 of 10. Required response:
  - outputs go to their reset values immediately;
  - after release, a new start with base 0x0100, len 2 yields 0x100 and 0x101 only.

Source files
------------

// File: rtl/crc_soc_pkg.sv
// rtl/crc_soc_pkg.sv - shared types and constants for the CRC SoC memory stream reader
package crc_soc_pkg;

    localparam int MEM_AW    = 16;
    localparam int DW        = 32;
    localparam int MEM_WORDS = 65536;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/crc_sync_fifo.sv
// rtl/crc_sync_fifo.sv - single-clock first-word-fall-through FIFO with registered count
module crc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] COUNT_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign head_data = storage[rd_ptr];
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crc_mem_stream_reader.sv
// rtl/crc_mem_stream_reader.sv - credit-limited read master streaming a memory block to the CRC engine
module crc_mem_stream_reader #(
    parameter int MEM_AW     = crc_soc_pkg::MEM_AW,
    parameter int DW         = crc_soc_pkg::DW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MEM_AW-1:0] base_addr,
    input  logic [MEM_AW:0]   len_words,
    output logic              busy,
    output logic              done,
    output logic [MEM_AW-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [MEM_AW:0] CNT_ONE = {{MEM_AW{1'b0}}, 1'b1};

    crc_soc_pkg::rd_state_t state;
    crc_soc_pkg::rd_state_t state_nxt;

    logic [MEM_AW-1:0] base_q;
    logic [MEM_AW:0]   len_q;
    logic [MEM_AW:0]   len_m1;
    logic [MEM_AW:0]   issued_q;
    logic [MEM_AW:0]   popped_q;
    logic              inflight;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [DW-1:0]     head_data;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              drain_exit;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign accept = (state == crc_soc_pkg::RD_IDLE) && start;
    assign len_m1 = len_q - CNT_ONE;

    // Credit uses only registered terms so out_ready never reaches mem_chipselect.
    assign issue = (state == crc_soc_pkg::RD_RUN)
                && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    assign mem_chipselect = issue;
    assign mem_address    = base_q + issued_q[MEM_AW-1:0];

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (popped_q == len_m1);
    assign out_data  = out_valid ? head_data : '0;

    assign busy = (state != crc_soc_pkg::RD_IDLE);
    assign done = (state == crc_soc_pkg::RD_DONE);

    // Leaving on the final handshake itself lets done land the cycle after it.
    assign drain_exit = (pop && out_last)
                     || (fifo_empty && !inflight && (popped_q == len_q));

    always_comb begin
        state_nxt = state;
        case (state)
            crc_soc_pkg::RD_IDLE: begin
                if (start) begin
                    state_nxt = (len_words == '0) ? crc_soc_pkg::RD_DONE : crc_soc_pkg::RD_RUN;
                end
            end
            crc_soc_pkg::RD_RUN: begin
                if (issue && (issued_q == len_m1)) begin
                    state_nxt = crc_soc_pkg::RD_DRAIN;
                end
            end
            crc_soc_pkg::RD_DRAIN: begin
                if (drain_exit) begin
                    state_nxt = crc_soc_pkg::RD_DONE;
                end
            end
            crc_soc_pkg::RD_DONE: begin
                state_nxt = crc_soc_pkg::RD_IDLE;
            end
            default: begin
                state_nxt = crc_soc_pkg::RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= crc_soc_pkg::RD_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= len_words;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + CNT_ONE;
                end
                if (pop) begin
                    popped_q <= popped_q + CNT_ONE;
                end
            end
        end
    end

    crc_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_readdata),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_crc_mem_stream_reader.sv
// tb/tb_crc_mem_stream_reader.sv - self-checking bench for crc_mem_stream_reader
module tb_crc_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] len_words;
    logic        busy;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata = 32'h0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;

    crc_mem_stream_reader #(
        .MEM_AW     (16),
        .DW         (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .len_words      (len_words),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference memory: upper half is a per-run salt, lower half the address.
    logic [15:0] salt = 16'h0;
    function automatic logic [31:0] mem_word(input logic [15:0] a, input logic [15:0] s);
        return {s, a};
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= mem_word(mem_address, salt);
    end

    int ready_pct = 100;
    always @(posedge clk) begin
        #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Observer
    int          start_cyc = 0;
    int          mon_rel;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_rel[$];
    int          done_rel, done_cnt, cs_cnt, xfer_cnt, valid_cnt;
    logic        busy_rel1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;

    task automatic clear_obs();
        got_d.delete();
        got_l.delete();
        got_rel.delete();
        done_rel  = -1;
        done_cnt  = 0;
        cs_cnt    = 0;
        xfer_cnt  = 0;
        valid_cnt = 0;
        busy_rel1 = 1'b0;
    endtask

    always @(negedge clk) begin
        mon_rel = cyc - start_cyc + 1;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_d));
                chk("stall_last", 64'(out_last), 64'(prev_l));
            end
            if (mem_chipselect) begin
                cs_cnt++;
                chk("credit_bound", 64'((cs_cnt - xfer_cnt) <= 4), 64'd1);
            end
            if (out_valid) valid_cnt++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                got_rel.push_back(mon_rel);
                xfer_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_rel = mon_rel;
            end
            if (mon_rel == 1) busy_rel1 = busy;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    task automatic run_block(input string tag, input logic [15:0] b, input int n, input int pct,
                             input logic [15:0] s, input int restart_at,
                             input int exp_first, input int exp_done);
        clear_obs();
        ready_pct = pct;
        salt      = s;
        @(negedge clk); #2;
        start     = 1'b1;
        base_addr = b;
        len_words = 17'(n);
        start_cyc = cyc + 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #2;
            start = (restart_at > 0) && ((cyc - start_cyc + 1) == restart_at);
            if (start) begin
                base_addr = 16'h0200;
                len_words = 17'd3;
            end else begin
                base_addr = 16'($urandom);
                len_words = 17'($urandom);
            end
            if (done_cnt != 0) break;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (3) begin
            @(negedge clk); #2;
        end
        chk({tag, "_word_count"}, 64'(got_d.size()), 64'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            logic [15:0] a;
            a = b + 16'(i);
            chk($sformatf("%s_w%0d_data", tag, i), 64'(got_d[i]), 64'(mem_word(a, s)));
            chk($sformatf("%s_w%0d_last", tag, i), 64'(got_l[i]), 64'(i == n - 1));
            if (exp_first >= 0)
                chk($sformatf("%s_w%0d_cycle", tag, i), 64'(got_rel[i]), 64'(exp_first + i));
        end
        if (exp_done >= 0) chk({tag, "_done_cycle"}, 64'(done_rel), 64'(exp_done));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_busy_cycle1"}, 64'(busy_rel1), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_reads"}, 64'(cs_cnt), 64'(n));
        if (n == 0) chk({tag, "_no_valid"}, 64'(valid_cnt), 64'd0);
    endtask

    typedef struct {
        string       tag;
        logic [15:0] base;
        int          len;
        int          pct;
        logic [15:0] salt;
        int          restart_at;
        int          exp_first;
        int          exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = 16'h0;
        len_words = 17'h0;

        vecs.push_back('{"basic8",   16'h0010,  8, 100, 16'h0000, 0,  3, 11});
        vecs.push_back('{"len0",     16'h0000,  0, 100, 16'h0000, 0, -1,  1});
        vecs.push_back('{"wrap",     16'hFFFE,  4, 100, 16'h0000, 0,  3,  7});
        vecs.push_back('{"len1",     16'h0ABC,  1, 100, 16'h1234, 0,  3,  4});
        vecs.push_back('{"bp16",     16'h0020, 16,  30, 16'hBEEF, 0, -1, -1});
        vecs.push_back('{"restart",  16'h0010,  8, 100, 16'h0000, 4,  3, 11});

        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cs", 64'(mem_chipselect), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("tie_write", 64'(mem_write), 64'd0);
        chk("tie_be", 64'(mem_byteenable), 64'hF);
        chk("tie_clken", 64'(mem_clken), 64'd1);
        reset = 1'b0;

        foreach (vecs[i])
            run_block(vecs[i].tag, vecs[i].base, vecs[i].len, vecs[i].pct, vecs[i].salt,
                      vecs[i].restart_at, vecs[i].exp_first, vecs[i].exp_done);

        for (int r = 0; r < 4; r++)
            run_block($sformatf("rand%0d", r), 16'($urandom), int'($urandom_range(1, 20)),
                      int'($urandom_range(30, 100)), 16'($urandom), 0, -1, -1);

        // Asynchronous reset while the fifth of ten words is on the stream
        clear_obs();
        ready_pct = 100;
        salt      = 16'h0;
        @(negedge clk); #2;
        start     = 1'b1;
        base_addr = 16'h0040;
        len_words = 17'd10;
        start_cyc = cyc + 1;
        @(negedge clk); #2;
        start = 1'b0;
        for (int k = 0; k < 200 && got_d.size() < 5; k++) begin
            @(negedge clk); #2;
        end
        chk("mid_reached_word5", 64'(got_d.size()), 64'd5);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_cs", 64'(mem_chipselect), 64'd0);
        chk("mid_rst_addr", 64'(mem_address), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        run_block("post_rst", 16'h0100, 2, 100, 16'h0000, 0, 3, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
